// File: rtl/mem_dump_tx_pkg.sv
// Shared constants, FSM encoding and timing helpers for the memory dump transmitter
// and its byte serializer.
package mem_dump_tx_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned BYTE_BITS = 10;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StFetch,
        StWait,
        StSend,
        StCsum,
        StCsumSend,
        StFin
    } state_e;

    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // Sync byte + memory bytes + checksum byte.
    function automatic int unsigned frame_len(input int unsigned addr_w);
        return (1 << addr_w) + 2;
    endfunction

    localparam int unsigned FRAME_LEN = frame_len(4);

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit, each DIV clocks.
// tx_ready is also high in the final clock of a stop bit so bytes can be sent back to back.
module uart_tx_byte
    import mem_dump_tx_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       txd
);

    localparam int unsigned     CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [3:0]      BIT_LAST = 4'(BYTE_BITS - 1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [9:0]       shift_q, shift_d;
    logic             bit_end;

    assign bit_end  = (cnt_q == CNT_LAST);
    assign tx_ready = !active_q || (bit_end && (bit_q == BIT_LAST));
    // Driven from reset-cleared state so a reset forces the line idle at once.
    assign txd      = active_q ? shift_q[0] : 1'b1;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        if (active_q) begin
            if (bit_end) begin
                cnt_d   = '0;
                bit_d   = bit_q + 4'd1;
                shift_d = {1'b1, shift_q[9:1]};
                if (bit_q == BIT_LAST) begin
                    active_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (tx_load && tx_ready) begin
            active_d = 1'b1;
            cnt_d    = '0;
            bit_d    = '0;
            shift_d  = {1'b1, tx_data, 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
        end
    end

endmodule

// File: rtl/mem_dump_tx.sv
// Dumps the whole program memory over UART as: sync byte, memory bytes, mod-256 checksum.
// Memory bytes are prefetched while the previous byte is still on the line.
module mem_dump_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              UART_TXD,
    output logic              busy,
    output logic              done
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);

    state_e            state_q, state_d;
    logic              start_q;
    logic              start_edge;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        csum_q;
    logic [7:0]        data_q;
    logic              tx_load;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              last_addr;

    assign start_edge = start && !start_q;
    assign last_addr  = (addr_q == '1);
    assign rd_addr    = addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start_edge) state_d = StSync;
            StSync:     state_d = StFetch;
            StFetch:    state_d = StWait;
            StWait:     state_d = StSend;
            StSend:     if (tx_ready) state_d = last_addr ? StCsum : StFetch;
            StCsum:     if (tx_ready) state_d = StCsumSend;
            StCsumSend: if (tx_ready) state_d = StFin;
            StFin:      state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_load = 1'b0;
        tx_data = 8'h00;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            StIdle: busy = 1'b0;
            StSync: begin
                tx_load = 1'b1;
                tx_data = SYNC_BYTE;
            end
            StSend: begin
                tx_load = tx_ready;
                tx_data = data_q;
            end
            StCsum: begin
                tx_load = tx_ready;
                tx_data = csum_q;
            end
            StFin: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b0;
            addr_q  <= '0;
            csum_q  <= '0;
            data_q  <= '0;
        end else begin
            start_q <= start;
            case (state_q)
                StSync: begin
                    addr_q <= '0;
                    csum_q <= '0;
                end
                StWait: begin
                    data_q <= rd_data;
                    csum_q <= csum_q + rd_data;
                end
                // Address stops at the last byte; it never wraps mid-dump.
                StSend: if (tx_ready && !last_addr) addr_q <= addr_q + 1'b1;
                StFin:  addr_q <= '0;
                default: ;
            endcase
        end
    end

    uart_tx_byte #(
        .DIV(DIV)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .tx_load (tx_load),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .txd     (UART_TXD)
    );

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx at DIV=4: a UART decoder pops expected bytes from a scoreboard queue.
module tb_mem_dump_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       UART_TXD;
    logic       busy;
    logic       done;

    logic [7:0] mem [16];
    logic [7:0] exp_q [$];

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int done_wide = 0;
    int busy_run  = 0;
    int last_busy = 0;
    int bytes_seen = 0;
    int dec_cnt   = 0;
    bit dec_active = 0;
    logic [39:0] samples;

    mem_dump_tx #(
        .CLK_FREQ(40),
        .BAUD    (10),
        .ADDR_W  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .UART_TXD(UART_TXD),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_byte();
        bit framing_ok;
        logic [7:0] val;
        framing_ok = (samples[2] == 1'b0) && (samples[38] == 1'b1);
        for (int b = 0; b < 10; b++)
            for (int k = 0; k < 4; k++)
                if (samples[4*b+k] !== samples[4*b]) framing_ok = 0;
        for (int j = 0; j < 8; j++) val[j] = samples[4*(j+1)+2];
        chk("byte_framing", framing_ok, 1);
        if (exp_q.size() == 0) begin
            chk("unexpected_byte", val, 32'hFFFF_FFFF);
        end else begin
            chk("byte_value", val, exp_q.pop_front());
        end
        bytes_seen++;
    endtask

    // UART decoder / scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                dec_active = 0;
            end else if (!dec_active) begin
                if (UART_TXD == 1'b0) begin
                    dec_active = 1;
                    dec_cnt    = 0;
                    samples[0] = 1'b0;
                end
            end else begin
                dec_cnt++;
                samples[dec_cnt] = UART_TXD;
                if (dec_cnt == 39) begin
                    dec_active = 0;
                    check_byte();
                end
            end
        end
    end

    // done / busy monitor.
    initial begin
        bit done_prev = 0;
        bit busy_prev = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_prev) done_wide++;
            end
            if (busy === 1'b1) busy_run++;
            else if (busy_prev) begin
                last_busy = busy_run;
                busy_run  = 0;
            end
            done_prev = (done === 1'b1);
            busy_prev = (busy === 1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem(input bit all_ff);
        for (int i = 0; i < 16; i++) mem[i] = all_ff ? 8'hFF : 8'(i);
    endtask

    task automatic push_frame(input bit all_ff);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 16; i++) exp_q.push_back(all_ff ? 8'hFF : 8'(i));
        exp_q.push_back(all_ff ? 8'hF0 : 8'h78);
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input string name, input int base);
        int n = 0;
        while (done_cnt == base && n < 1500) begin
            tick();
            n++;
        end
        chk({name, "_done_seen"}, (done_cnt != base), 1);
    endtask

    task automatic finish_dump(input string name, input int done_base, input int wide_base);
        wait_done(name, done_base);
        repeat (6) tick();
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        chk({name, "_done_count"}, done_cnt - done_base, 1);
        chk({name, "_done_width"}, done_wide - wide_base, 0);
        chk({name, "_busy_idle"}, busy, 0);
        chk({name, "_addr_idle"}, rd_addr, 0);
        chk_range({name, "_busy_len"}, last_busy, 717, 723);
    endtask

    initial begin
        int db;
        int wb;
        int n;
        rst   = 0;
        start = 0;
        load_mem(0);
        repeat (3) tick();
        chk("rst_txd", UART_TXD, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rd_addr, 0);
        rst = 1;
        repeat (10) tick();
        chk("idle_txd", UART_TXD, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_addr", rd_addr, 0);

        // Incrementing memory.
        db = done_cnt; wb = done_wide;
        push_frame(0);
        pulse_start();
        chk("busy_rise", busy, 1);
        finish_dump("inc", db, wb);

        // All 0xFF: checksum wraps to 0xF0.
        load_mem(1);
        db = done_cnt; wb = done_wide;
        push_frame(1);
        pulse_start();
        finish_dump("ff", db, wb);

        // Second start mid-dump is ignored.
        load_mem(0);
        db = done_cnt; wb = done_wide;
        push_frame(0);
        n = bytes_seen;
        pulse_start();
        for (int i = 0; i < 400 && bytes_seen < n + 5; i++) tick();
        chk("restart_reach_byte5", bytes_seen - n, 5);
        start = 1;
        repeat (2) tick();
        start = 0;
        finish_dump("restart", db, wb);

        // start held high gives exactly one dump.
        db = done_cnt; wb = done_wide;
        push_frame(0);
        start = 1;
        repeat (2000) tick();
        start = 0;
        repeat (10) tick();
        chk("held_done_count", done_cnt - db, 1);
        chk("held_done_width", done_wide - wb, 0);
        chk("held_queue_empty", exp_q.size(), 0);

        // Reset during bit d3 of memory byte 7, then a clean dump.
        push_frame(0);
        n = bytes_seen;
        pulse_start();
        for (int i = 0; i < 600 && !(bytes_seen == n + 8 && dec_active && dec_cnt == 17); i++)
            tick();
        chk("midrst_reach_bit3", (bytes_seen == n + 8 && dec_active && dec_cnt == 17), 1);
        rst = 0;
        exp_q.delete();
        #1;
        chk("midrst_txd", UART_TXD, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", rd_addr, 0);
        repeat (3) tick();
        rst = 1;
        repeat (5) tick();
        chk("midrst_idle_txd", UART_TXD, 1);
        db = done_cnt; wb = done_wide;
        push_frame(0);
        pulse_start();
        finish_dump("post_rst", db, wb);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
